// File: rtl/zrl_pkg.sv
// zrl_pkg: shared definitions for the ZRL decompressor.
//   - chunk / word / symbol widths
//   - prefix codes and their symbol sizes
//   - SOP header constant
//   - FSM state type and decoder result struct
package zrl_pkg;

  localparam int CHUNK_W = 16;
  localparam int NCHUNK  = 4;
  localparam int DATA_W  = CHUNK_W * NCHUNK;  // 64
  localparam int SYM_W   = 68;
  localparam int SIZE_W  = 7;

  localparam logic [1:0] SOP_HDR = 2'b01;
  localparam logic [SIZE_W-1:0] SOP_HDR_SZ = 7'd2;

  // Symbol sizes by prefix class (header excluded)
  localparam logic [SIZE_W-1:0] SZ_ZERO = 7'd6;   // 000000
  localparam logic [SIZE_W-1:0] SZ_C0   = 7'd22;  // 000001
  localparam logic [SIZE_W-1:0] SZ_ONE  = 7'd21;  // 00001/00010/00011
  localparam logic [SIZE_W-1:0] SZ_TWO  = 7'd36;  // 0010..0111
  localparam logic [SIZE_W-1:0] SZ_THR  = 7'd52;  // 1000..1011
  localparam logic [SIZE_W-1:0] SZ_FULL = 7'd66;  // 11

  // Prefix constants
  localparam logic [5:0] P_ZERO = 6'b000000;
  localparam logic [5:0] P_C0   = 6'b000001;
  localparam logic [4:0] P_C1   = 5'b00001;
  localparam logic [4:0] P_C2   = 5'b00010;
  localparam logic [4:0] P_C3   = 5'b00011;
  localparam logic [3:0] P_C10  = 4'b0010;
  localparam logic [3:0] P_C20  = 4'b0011;
  localparam logic [3:0] P_C30  = 4'b0100;
  localparam logic [3:0] P_C21  = 4'b0101;
  localparam logic [3:0] P_C31  = 4'b0110;
  localparam logic [3:0] P_C32  = 4'b0111;
  localparam logic [3:0] P_C210 = 4'b1000;
  localparam logic [3:0] P_C310 = 4'b1001;
  localparam logic [3:0] P_C320 = 4'b1010;
  localparam logic [3:0] P_C321 = 4'b1011;
  localparam logic [1:0] P_FULL = 2'b11;

  typedef enum logic {ST_IDLE = 1'b0, ST_IN_PKT = 1'b1} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [SIZE_W-1:0] size;  // expected symbol size, header included
  } zrl_dec_t;

endpackage

// File: rtl/zrl_symbol_decode.sv
// zrl_symbol_decode: combinational prefix decode of one ZRL symbol.
//   sym_i : left-aligned symbol (first code bit at [67])
//   sop_i : symbol carries a 2-bit header which is stripped here
//   dec_o : decoded 64-bit word and expected symbol size
module zrl_symbol_decode
  import zrl_pkg::*;
(
  input  logic [SYM_W-1:0] sym_i,
  input  logic             sop_i,
  output zrl_dec_t         dec_o
);

  // Code field realigned so the prefix always starts at bit 67.
  logic [SYM_W-1:0]                w;
  logic [NCHUNK-1:0][CHUNK_W-1:0] ch;
  logic [SIZE_W-1:0]               tsz;
  logic                            unused_w;

  assign w        = sop_i ? {sym_i[SYM_W-3:0], 2'b00} : sym_i;
  assign unused_w = ^w[1:0];

  always_comb begin
    ch  = '0;
    tsz = SZ_ZERO;
    if (w[67:62] == P_ZERO) begin
      tsz = SZ_ZERO;
    end else if (w[67:62] == P_C0) begin
      ch[0] = w[61:46];
      tsz   = SZ_C0;
    end else if (w[67:63] == P_C1) begin
      ch[1] = w[62:47];
      tsz   = SZ_ONE;
    end else if (w[67:63] == P_C2) begin
      ch[2] = w[62:47];
      tsz   = SZ_ONE;
    end else if (w[67:63] == P_C3) begin
      ch[3] = w[62:47];
      tsz   = SZ_ONE;
    end else if (w[67:66] == P_FULL) begin
      ch  = w[65:2];
      tsz = SZ_FULL;
    end else begin
      // Remaining 4-bit prefixes: two or three chunks, highest index first.
      tsz = SZ_TWO;
      unique case (w[67:64])
        P_C10:  begin ch[1] = w[63:48]; ch[0] = w[47:32]; end
        P_C20:  begin ch[2] = w[63:48]; ch[0] = w[47:32]; end
        P_C30:  begin ch[3] = w[63:48]; ch[0] = w[47:32]; end
        P_C21:  begin ch[2] = w[63:48]; ch[1] = w[47:32]; end
        P_C31:  begin ch[3] = w[63:48]; ch[1] = w[47:32]; end
        P_C32:  begin ch[3] = w[63:48]; ch[2] = w[47:32]; end
        P_C210: begin ch[2] = w[63:48]; ch[1] = w[47:32]; ch[0] = w[31:16]; tsz = SZ_THR; end
        P_C310: begin ch[3] = w[63:48]; ch[1] = w[47:32]; ch[0] = w[31:16]; tsz = SZ_THR; end
        P_C320: begin ch[3] = w[63:48]; ch[2] = w[47:32]; ch[0] = w[31:16]; tsz = SZ_THR; end
        P_C321: begin ch[3] = w[63:48]; ch[2] = w[47:32]; ch[1] = w[31:16]; tsz = SZ_THR; end
        default: ;
      endcase
    end
  end

  assign dec_o.data = ch;
  assign dec_o.size = tsz + (sop_i ? SOP_HDR_SZ : '0);

endmodule

// File: rtl/zrl_decomp.sv
// zrl_decomp: ZRL stream decoder, one symbol per beat, 1-cycle latency.
//   clk, rst_n          : clock, synchronous active-low reset
//   data_i/size_i       : left-aligned symbol and its length in bits
//   sop_i/eop_i         : packet delimiters (sop symbols carry 2'b01 header)
//   valid_i/ready_o     : input handshake
//   data_o              : decoded 64-bit word
//   sop_o/eop_o/err_o   : per-beat flags
//   words_o             : beats in packet so far, including this one
//   valid_o/ready_i     : output handshake
// Build option: ZRLD_SIZE_CHECK_EN adds a size_i vs. table-size check.
module zrl_decomp
  import zrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SYM_W-1:0]  data_i,
  input  logic [SIZE_W-1:0] size_i,
  input  logic              sop_i,
  input  logic              eop_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] data_o,
  output logic              sop_o,
  output logic              eop_o,
  output logic              err_o,
  output logic [15:0]       words_o,
  output logic              valid_o,
  input  logic              ready_i
);

  zrl_dec_t dec;

  zrl_symbol_decode u_dec (
    .sym_i (data_i),
    .sop_i (sop_i),
    .dec_o (dec)
  );

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q;
  logic              sop_q, eop_q, err_q, valid_q;
  logic [15:0]       words_q;

  logic accept, pkt_start, hdr_err, seq_err, size_err, err_d;

  // Reset term keeps ready_o high while a held beat is being flushed.
  assign ready_o   = !rst_n || !valid_q || ready_i;
  assign accept    = valid_i && ready_o;
  // A beat without sop in IDLE is still treated as a packet start.
  assign pkt_start = sop_i || (state_q == ST_IDLE);
  assign hdr_err   = sop_i && (data_i[67:66] != SOP_HDR);
  // sop missing in IDLE, or sop arriving mid-packet.
  assign seq_err   = sop_i ^ (state_q == ST_IDLE);

`ifdef ZRLD_SIZE_CHECK_EN
  assign size_err = (size_i != dec.size);
`else
  logic unused_size;
  assign size_err    = 1'b0;
  assign unused_size = ^{size_i, dec.size};
`endif

  assign err_d = hdr_err || seq_err || size_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = eop_i ? ST_IDLE : ST_IN_PKT;
      if (pkt_start)            cnt_d = 16'd1;
      else if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      err_q   <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        valid_q <= 1'b1;
        data_q  <= dec.data;
        sop_q   <= sop_i;
        eop_q   <= eop_i;
        err_q   <= err_d;
        words_q <= cnt_d;
      end else if (ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sop_o   = sop_q;
  assign eop_o   = eop_q;
  assign err_o   = err_q;
  assign words_o = words_q;

endmodule

// File: doc/zrl_decomp.md
ZRL_DECOMP -- requirements
Module: zrl_decomp

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, synchronous and active-low.
REQ-003 data_i  input  68  one ZRL symbol, left-aligned (first code bit at bit 67), unused LSBs don't-care.
REQ-004 size_i  input  7  symbol length in bits (6..68).
REQ-005 sop_i / eop_i  input  1 each  first / last symbol of packet; sop symbols carry 2'b01 header.
REQ-006 valid_i  input  1 / ready_o  output  1  input handshake; transfer when both high.
REQ-007 data_o  output  64  decoded word.
REQ-008 sop_o / eop_o / err_o  output  1 each  qualified by valid_o.
REQ-009 words_o  output  16  beats in packet including current; meaningful on eop_o beat.
REQ-010 valid_o  output  1 / ready_i  input  1  output handshake.

Function
REQ-011 Decoder SHALL accept the stream produced by the team's ZRL encoder, one symbol per input beat; latency exactly 1 cycle from input transfer to valid_o.
REQ-012 When sop_i=1, bits 67:66 SHALL be checked against 2'b01 and stripped; decode continues at bit 65; expected size +2.
REQ-013 Prefix table (payload 16-bit chunks, highest index first; chunk k = data_o[16k+15:16k]; absent chunks = 0): 000000 none/6; 000001 c0/22; 00001 c1/21; 00010 c2/21; 00011 c3/21; 0010 c1,c0/36; 0011 c2,c0/36; 0100 c3,c0/36; 0101 c2,c1/36; 0110 c3,c1/36; 0111 c3,c2/36; 1000 c2,c1,c0/52; 1001 c3,c1,c0/52; 1010 c3,c2,c0/52; 1011 c3,c2,c1/52; 11 full 64 bits/66.
REQ-014 Every prefix is legal; no illegal-code state exists.
REQ-015 Output stage is a single register slice: ready_o = !valid_o | ready_i; while valid_o=1 and ready_i=0, all outputs SHALL hold stable.
REQ-016 FSM states IDLE, IN_PKT: IDLE->IN_PKT on accepted beat with eop_i=0; IN_PKT->IDLE on accepted beat with eop_i=1; sop_i&eop_i together = single-beat packet, stays/returns IDLE.
REQ-017 err_o=1 on beat if: header != 2'b01 with sop_i; sop_i=0 while IDLE (beat decoded and treated as packet start); sop_i=1 while IN_PKT (new packet starts, count restarts); size mismatch per REQ-022.
REQ-018 Erroneous beats SHALL still be decoded and forwarded; err_o is per-beat, not sticky.
REQ-019 Beat counter SHALL reset to 1 on packet start, increment per accepted beat, saturate at 16'hFFFF; words_o = counter value for that beat.

Reset
REQ-020 On rst_n=0 at clk edge: valid_o, sop_o, eop_o, err_o=0; data_o=0; words_o=0; FSM=IDLE; counter=0; any held output beat discarded.
REQ-021 ready_o SHALL be 1 during and immediately after reset.

Configuration
REQ-022 Macro ZRLD_SIZE_CHECK_EN defined: size_i compared with table size (+2 on sop), mismatch sets err_o; undefined: size_i ignored, no size comparison logic synthesized.

Structure
REQ-023 Shared package zrl_pkg: prefix constants, per-code sizes, SOP header constant 2'b01, FSM state type, chunk width 16.
REQ-024 Sub-module zrl_symbol_decode: combinational prefix decode to {data, expected size}; zrl_decomp owns handshake, FSM, counter, errors.

Verification
REQ-025 sop_i=eop_i=1, data_i={2'b01,6'b0,60'b0}, size 8 -> next cycle data_o=0, sop_o=eop_o=1, words_o=1, err_o=0.
REQ-026 Packet sop {2'b01,4'b0011,16'hBEEF,16'h1234,30'b0}/38, then {2'b11,64'h0123456789ABCDEF,2'b0}/66 with eop -> data_o 64'h0000BEEF00001234 then 64'h0123456789ABCDEF, words_o=2, err_o=0.
REQ-027 ready_i low 3 cycles with valid_o=1 -> ready_o=0, outputs stable; resume loses/duplicates no beat.
REQ-028 Non-sop {6'b000001,16'hA5A5,46'b0} size 21 in IN_PKT -> data_o=64'hA5A5, err_o=1 with ZRLD_SIZE_CHECK_EN, 0 without.
REQ-029 sop beat with header 2'b10 -> err_o=1; non-sop beat in IDLE -> err_o=1; rst_n low mid-packet -> valid_o=0 next cycle, next sop beat words_o=1.
